// File: rtl/block_memory_responder.sv
// block_memory_responder
//
// Main-memory responder that sits behind the instruction and data caches.
// It answers 256-bit block reads and writes from two requesters (I-side and
// D-side) out of an internal block array after a fixed access latency. When
// both sides request at once, the side that was not served last is granted.
// Each side sees a one-cycle done pulse when its transaction completes.
//
// Parameters:
//   DEPTH_BLKS  number of 256-bit blocks in the array (power of two, >= 2)
//   LATENCY     cycles from request acceptance to done (1..255)
//
// Ports:
//   CLK                  clock, rising edge
//   RESET                asynchronous active-low reset
//   iBlkRead/iBlkWrite   I-side request levels, held until done
//   iAddr                I-side byte address (bits [4:0] ignored)
//   block_write_fIC      I-side write block, held with the request
//   block_read_2IC       I-side read block, registered
//   iBlkDone             I-side completion pulse
//   dBlkRead/dBlkWrite, dAddr, block_write_fDC, block_read_2DC, dBlkDone
//                        D-side equivalents
//   mem_busy             high whenever a transaction is in progress
module block_memory_responder #(
  parameter int DEPTH_BLKS = 1024,
  parameter int LATENCY    = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         iBlkRead,
  input  logic         iBlkWrite,
  input  logic [31:0]  iAddr,
  input  logic [255:0] block_write_fIC,
  output logic [255:0] block_read_2IC,
  output logic         iBlkDone,
  input  logic         dBlkRead,
  input  logic         dBlkWrite,
  input  logic [31:0]  dAddr,
  input  logic [255:0] block_write_fDC,
  output logic [255:0] block_read_2DC,
  output logic         dBlkDone,
  output logic         mem_busy
);

  localparam int IDX_W = $clog2(DEPTH_BLKS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  // Block storage; deliberately not reset so contents survive RESET.
  logic [255:0] mem [DEPTH_BLKS];

  logic [1:0]       state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt_port_q, gnt_port_d;
  logic             gnt_write_q, gnt_write_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             i_done_q, i_done_d;
  logic             d_done_q, d_done_d;
  logic [255:0]     i_rdata_q, i_rdata_d;
  logic [255:0]     d_rdata_q, d_rdata_d;

  logic             i_req;
  logic             d_req;
  logic             grant_sel;
  logic             commit;
  logic             mem_we;
  logic [255:0]     mem_rdata;
  logic [255:0]     mem_wdata;

  // Address bits outside the block index are intentionally dropped, so
  // out-of-range addresses alias modulo DEPTH_BLKS.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{iAddr[31:IDX_W+5], iAddr[4:0],
                              dAddr[31:IDX_W+5], dAddr[4:0]};

  assign i_req = iBlkRead | iBlkWrite;
  assign d_req = dBlkRead | dBlkWrite;

  // The commit edge is the last BUSY edge: array write, read capture and
  // done all happen there together.
  assign commit    = (state_q == ST_BUSY) && (cnt_q == 8'd0);
  assign mem_rdata = mem[gnt_idx_q];
  // Write data is taken live from the granted port at the commit edge.
  assign mem_wdata = (gnt_port_q == PORT_D) ? block_write_fDC : block_write_fIC;
  assign mem_we    = commit && gnt_write_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    gnt_port_d   = gnt_port_q;
    gnt_write_d  = gnt_write_q;
    gnt_idx_d    = gnt_idx_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_sel    = PORT_I;

    case (state_q)
      ST_IDLE: begin
        if (i_req || d_req) begin
          // On a conflict the port not served last wins; last_grant
          // resets to I so D wins the first conflict.
          if (i_req && d_req) begin
            grant_sel = ~last_grant_q;
          end else begin
            grant_sel = d_req ? PORT_D : PORT_I;
          end
          gnt_port_d = grant_sel;
          // Read and Write together on one port is treated as a write.
          gnt_write_d = (grant_sel == PORT_D) ? dBlkWrite : iBlkWrite;
          gnt_idx_d   = (grant_sel == PORT_D) ? dAddr[IDX_W+4:5] : iAddr[IDX_W+4:5];
          cnt_d       = CNT_LOAD;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_DONE;
          if (gnt_port_q == PORT_D) begin
            d_done_d = 1'b1;
            if (!gnt_write_q) d_rdata_d = mem_rdata;
          end else begin
            i_done_d = 1'b1;
            if (!gnt_write_q) i_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_DONE: begin
        last_grant_d = gnt_port_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      last_grant_q <= PORT_I;
      gnt_port_q   <= PORT_I;
      gnt_write_q  <= 1'b0;
      gnt_idx_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      gnt_port_q   <= gnt_port_d;
      gnt_write_q  <= gnt_write_d;
      gnt_idx_q    <= gnt_idx_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Reset forces state to IDLE, which deasserts mem_we, so an abandoned
  // write never reaches the array.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[gnt_idx_q] <= mem_wdata;
    end
  end

  assign block_read_2IC = i_rdata_q;
  assign block_read_2DC = d_rdata_q;
  assign iBlkDone       = i_done_q;
  assign dBlkDone       = d_done_q;
  assign mem_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_block_memory_responder.sv
// tb_block_memory_responder
//
// Directed bench for block_memory_responder. The main instance uses
// LATENCY=4 and DEPTH_BLKS=1024; a second instance uses LATENCY=1 for the
// minimum-latency case. Inputs are driven 1 time unit after a rising edge
// and outputs are sampled at the same point.
module tb_block_memory_responder;

  logic         CLK;
  logic         RESET;
  logic         iBlkRead, iBlkWrite, dBlkRead, dBlkWrite;
  logic [31:0]  iAddr, dAddr;
  logic [255:0] block_write_fIC, block_write_fDC;
  logic [255:0] block_read_2IC, block_read_2DC;
  logic         iBlkDone, dBlkDone, mem_busy;

  logic         l1_iRead, l1_iWrite, l1_dRead, l1_dWrite;
  logic [31:0]  l1_iAddr, l1_dAddr;
  logic [255:0] l1_iWdata, l1_dWdata, l1_iRdata, l1_dRdata;
  logic         l1_iDone, l1_dDone, l1_busy;

  int checks;
  int failures;

  localparam logic [255:0] PAT_A5   = {32{8'hA5}};
  localparam logic [255:0] PAT_1234 = 256'h1234;
  localparam logic [255:0] PAT_WRAP = {8{32'hDEADBEEF}};
  localparam logic [255:0] PAT_X    = {4{64'h0123456789ABCDEF}};
  localparam logic [255:0] PAT_Y    = {4{64'hFEDCBA9876543210}};
  localparam logic [255:0] PAT_L1   = {16{16'hC0DE}};

  block_memory_responder #(.DEPTH_BLKS(1024), .LATENCY(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .iBlkRead(iBlkRead), .iBlkWrite(iBlkWrite), .iAddr(iAddr),
    .block_write_fIC(block_write_fIC), .block_read_2IC(block_read_2IC),
    .iBlkDone(iBlkDone),
    .dBlkRead(dBlkRead), .dBlkWrite(dBlkWrite), .dAddr(dAddr),
    .block_write_fDC(block_write_fDC), .block_read_2DC(block_read_2DC),
    .dBlkDone(dBlkDone),
    .mem_busy(mem_busy)
  );

  block_memory_responder #(.DEPTH_BLKS(1024), .LATENCY(1)) dut1 (
    .CLK(CLK), .RESET(RESET),
    .iBlkRead(l1_iRead), .iBlkWrite(l1_iWrite), .iAddr(l1_iAddr),
    .block_write_fIC(l1_iWdata), .block_read_2IC(l1_iRdata),
    .iBlkDone(l1_iDone),
    .dBlkRead(l1_dRead), .dBlkWrite(l1_dWrite), .dAddr(l1_dAddr),
    .block_write_fDC(l1_dWdata), .block_read_2DC(l1_dRdata),
    .dBlkDone(l1_dDone),
    .mem_busy(l1_busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic pulse_reset();
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  // Runs one transaction on the main instance, returning the number of
  // edges from the sampling edge (counted as 1) to the first cycle where
  // done is seen; 0 means the wait ran out. Leaves one idle edge after.
  task automatic do_txn(input bit dside, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [255:0] wdata,
                        output int cycles, output bit other_done,
                        output bit busy_at_done);
    cycles = 0;
    other_done = 1'b0;
    busy_at_done = 1'b0;
    if (dside) begin
      dAddr = addr; block_write_fDC = wdata; dBlkRead = rd; dBlkWrite = wr;
    end else begin
      iAddr = addr; block_write_fIC = wdata; iBlkRead = rd; iBlkWrite = wr;
    end
    for (int n = 1; n <= 64; n++) begin
      @(posedge CLK);
      #1;
      if (dside ? iBlkDone : dBlkDone) other_done = 1'b1;
      if (dside ? dBlkDone : iBlkDone) begin
        cycles = n;
        busy_at_done = mem_busy;
        break;
      end
    end
    if (dside) begin
      dBlkRead = 1'b0; dBlkWrite = 1'b0;
    end else begin
      iBlkRead = 1'b0; iBlkWrite = 1'b0;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (iBlkDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_iDone: got %b expected 0", iBlkDone); end
    checks++; if (dBlkDone !== 1'b0) begin failures++; $display("[TB] FAIL reset_dDone: got %b expected 0", dBlkDone); end
    checks++; if (mem_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", mem_busy); end
    checks++; if (block_read_2IC !== 256'h0) begin failures++; $display("[TB] FAIL reset_rdataI: got %h expected 0", block_read_2IC); end
    checks++; if (block_read_2DC !== 256'h0) begin failures++; $display("[TB] FAIL reset_rdataD: got %h expected 0", block_read_2DC); end
    @(posedge CLK);
    #1;
    RESET = 1'b1;
  endtask

  task automatic test_single_read();
    int  cyc;
    bit  other, busy;
    // Preload block 3 through the D-side write path.
    do_txn(1'b1, 1'b0, 1'b1, 32'h60, PAT_A5, cyc, other, busy);
    checks++; if (cyc !== 5) begin failures++; $display("[TB] FAIL preload_latency: got %0d expected 5", cyc); end
    checks++; if (block_read_2DC !== 256'h0) begin failures++; $display("[TB] FAIL write_keeps_rdataD: got %h expected 0", block_read_2DC); end
    do_txn(1'b1, 1'b1, 1'b0, 32'h60, 256'h0, cyc, other, busy);
    checks++; if (cyc !== 5) begin failures++; $display("[TB] FAIL dread_latency: got %0d expected 5", cyc); end
    checks++; if (block_read_2DC !== PAT_A5) begin failures++; $display("[TB] FAIL dread_data: got %h expected %h", block_read_2DC, PAT_A5); end
    checks++; if (other !== 1'b0) begin failures++; $display("[TB] FAIL dread_iDone_quiet: got %b expected 0", other); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL dread_busy_in_done: got %b expected 1", busy); end
    // One edge past the done cycle: pulse gone, back to idle.
    checks++; if (dBlkDone !== 1'b0) begin failures++; $display("[TB] FAIL dread_done_one_cycle: got %b expected 0", dBlkDone); end
    checks++; if (mem_busy !== 1'b0) begin failures++; $display("[TB] FAIL dread_busy_after: got %b expected 0", mem_busy); end
  endtask

  task automatic test_write_read_i();
    int  cyc;
    bit  other, busy;
    do_txn(1'b0, 1'b1, 1'b0, 32'h60, 256'h0, cyc, other, busy);
    checks++; if (block_read_2IC !== PAT_A5) begin failures++; $display("[TB] FAIL iread_first: got %h expected %h", block_read_2IC, PAT_A5); end
    do_txn(1'b0, 1'b0, 1'b1, 32'h20, PAT_1234, cyc, other, busy);
    checks++; if (cyc !== 5) begin failures++; $display("[TB] FAIL iwrite_latency: got %0d expected 5", cyc); end
    checks++; if (block_read_2IC !== PAT_A5) begin failures++; $display("[TB] FAIL iwrite_keeps_rdata: got %h expected %h", block_read_2IC, PAT_A5); end
    do_txn(1'b0, 1'b1, 1'b0, 32'h20, 256'h0, cyc, other, busy);
    checks++; if (block_read_2IC !== PAT_1234) begin failures++; $display("[TB] FAIL iread_after_write: got %h expected %h", block_read_2IC, PAT_1234); end
  endtask

  task automatic test_conflict();
    int d_first, d_second, i_done_n, d_count;
    pulse_reset();
    d_first = 0; d_second = 0; i_done_n = 0; d_count = 0;
    // Both sides request at once. D keeps its request up after its first
    // done, so it competes again with the still-pending I request.
    dAddr = 32'h60; dBlkRead = 1'b1;
    iAddr = 32'h20; iBlkRead = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge CLK);
      #1;
      if (dBlkDone) begin
        d_count++;
        if (d_count == 1) d_first = n;
        else begin d_second = n; dBlkRead = 1'b0; end
      end
      if (iBlkDone) begin
        i_done_n = n;
        iBlkRead = 1'b0;
      end
      if (d_second != 0 && i_done_n != 0) break;
    end
    dBlkRead = 1'b0; iBlkRead = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (d_first !== 5) begin failures++; $display("[TB] FAIL conflict_d_first: got %0d expected 5", d_first); end
    checks++; if (i_done_n !== 11) begin failures++; $display("[TB] FAIL conflict_i_done: got %0d expected 11", i_done_n); end
    checks++; if (d_second !== 17) begin failures++; $display("[TB] FAIL conflict_repeat_d: got %0d expected 17", d_second); end
    checks++; if (block_read_2IC !== PAT_1234) begin failures++; $display("[TB] FAIL conflict_i_data: got %h expected %h", block_read_2IC, PAT_1234); end
    checks++; if (block_read_2DC !== PAT_A5) begin failures++; $display("[TB] FAIL conflict_d_data: got %h expected %h", block_read_2DC, PAT_A5); end
  endtask

  task automatic test_wrap();
    int  cyc;
    bit  other, busy;
    do_txn(1'b1, 1'b0, 1'b1, 32'h8000, PAT_WRAP, cyc, other, busy);
    do_txn(1'b1, 1'b1, 1'b0, 32'h0, 256'h0, cyc, other, busy);
    checks++; if (cyc !== 5) begin failures++; $display("[TB] FAIL wrap_latency: got %0d expected 5", cyc); end
    checks++; if (block_read_2DC !== PAT_WRAP) begin failures++; $display("[TB] FAIL wrap_data: got %h expected %h", block_read_2DC, PAT_WRAP); end
  endtask

  task automatic test_reset_mid_busy();
    int  cyc;
    bit  other, busy, seen_done;
    do_txn(1'b1, 1'b0, 1'b1, 32'hA0, PAT_X, cyc, other, busy);
    iAddr = 32'hA0; block_write_fIC = PAT_Y; iBlkWrite = 1'b1;
    @(posedge CLK);
    #1;
    checks++; if (mem_busy !== 1'b1) begin failures++; $display("[TB] FAIL midbusy_accepted: got %b expected 1", mem_busy); end
    repeat (2) begin @(posedge CLK); #1; end
    RESET = 1'b0;
    #1;
    checks++; if (mem_busy !== 1'b0) begin failures++; $display("[TB] FAIL midbusy_busy_cleared: got %b expected 0", mem_busy); end
    iBlkWrite = 1'b0;
    seen_done = 1'b0;
    for (int n = 0; n < 6; n++) begin
      if (n == 2) RESET = 1'b1;
      @(posedge CLK);
      #1;
      if (iBlkDone || dBlkDone) seen_done = 1'b1;
    end
    RESET = 1'b1;
    checks++; if (seen_done !== 1'b0) begin failures++; $display("[TB] FAIL midbusy_no_done: got %b expected 0", seen_done); end
    do_txn(1'b0, 1'b1, 1'b0, 32'hA0, 256'h0, cyc, other, busy);
    checks++; if (block_read_2IC !== PAT_X) begin failures++; $display("[TB] FAIL midbusy_old_data: got %h expected %h", block_read_2IC, PAT_X); end
  endtask

  task automatic test_latency1();
    int n_done;
    n_done = 0;
    l1_iAddr = 32'h40; l1_iWdata = PAT_L1; l1_iRead = 1'b1; l1_iWrite = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge CLK);
      #1;
      if (l1_iDone) begin n_done = n; break; end
    end
    l1_iRead = 1'b0; l1_iWrite = 1'b0;
    checks++; if (n_done !== 2) begin failures++; $display("[TB] FAIL lat1_rw_latency: got %0d expected 2", n_done); end
    checks++; if (l1_iRdata !== 256'h0) begin failures++; $display("[TB] FAIL lat1_rw_not_read: got %h expected 0", l1_iRdata); end
    @(posedge CLK);
    #1;
    n_done = 0;
    l1_iRead = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge CLK);
      #1;
      if (l1_iDone) begin n_done = n; break; end
    end
    l1_iRead = 1'b0;
    checks++; if (n_done !== 2) begin failures++; $display("[TB] FAIL lat1_read_latency: got %0d expected 2", n_done); end
    checks++; if (l1_iRdata !== PAT_L1) begin failures++; $display("[TB] FAIL lat1_read_data: got %h expected %h", l1_iRdata, PAT_L1); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RESET = 1'b1;
    iBlkRead = 1'b0; iBlkWrite = 1'b0; iAddr = '0; block_write_fIC = '0;
    dBlkRead = 1'b0; dBlkWrite = 1'b0; dAddr = '0; block_write_fDC = '0;
    l1_iRead = 1'b0; l1_iWrite = 1'b0; l1_iAddr = '0; l1_iWdata = '0;
    l1_dRead = 1'b0; l1_dWrite = 1'b0; l1_dAddr = '0; l1_dWdata = '0;

    test_reset();
    test_single_read();
    test_write_read_i();
    test_conflict();
    test_wrap();
    test_reset_mid_busy();
    test_latency1();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_memory_responder.md
# block_memory_responder

Main-memory responder for the instruction and data caches. It answers the 256-bit block read and write requests the caches issue on a miss or eviction, using an internal block array and a fixed access latency. It arbitrates between the I-side and D-side request ports and signals completion to each requester with a one-cycle done pulse. It sits outside the MIPS core, on the far side of the block-transfer interface.

## Interface
Parameters:
- DEPTH_BLKS, 1024: number of 256-bit blocks in the array; must be a power of two.
- LATENCY, 4: cycles from request acceptance to done; legal range 1..255.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  reset, asynchronous, active-low.
- iBlkRead  in  1  I-side block read request; level, held until done.
- iBlkWrite  in  1  I-side block write request; level, held until done.
- iAddr  in  32  I-side byte address; bits [4:0] ignored.
- block_write_fIC  in  256  I-side write block; held with the request.
- block_read_2IC  out  256  I-side read block; registered.
- iBlkDone  out  1  I-side completion pulse.
- dBlkRead, dBlkWrite, dAddr, block_write_fDC, block_read_2DC, dBlkDone: D-side equivalents of the I-side ports, with identical widths and meaning.
- mem_busy  out  1  high when state is not IDLE.

## Operation
- Block index = addr[log2(DEPTH_BLKS)+4 : 5]. Higher address bits are dropped, so out-of-range addresses wrap modulo DEPTH_BLKS.
- The FSM has three states: IDLE, BUSY, DONE.
- **IDLE:**
  - At each edge, sample the requests. A port is requesting if its Read or Write input is high.
  - If no port is requesting, stay in IDLE.
  - If exactly one port is requesting, grant that port.
  - If both ports are requesting, grant the port that was not granted last. The last-grant register resets to I, so D wins the first conflict.
  - On a grant: latch the port id, the op (write if the port's Write input is high, else read), and the index; load cnt = LATENCY-1; go to BUSY.
- **BUSY:**
  - While cnt ≠ 0, decrement cnt each cycle.
  - At the edge where cnt = 0, go to DONE.
  - On that same edge, for a write, array[index] <= the granted port's write block (sampled at this edge).
  - On that same edge, for a read, the granted port's block_read_2xC <= array[index].
  - On that same edge, the granted port's done register goes to 1.
- **DONE:**
  - The done signal is high for exactly this one cycle.
  - At the next edge, done returns to 0, last-grant is set to the granted port, and the FSM goes to IDLE.
- Requester obligation: hold req, addr and write data stable from assertion through the done cycle, and deassert req at the edge ending the done cycle. A request still high in IDLE is treated as a new transaction.
- Read and Write asserted together on one port: treated as a write.
- The ungranted port's request is simply left pending. It is never dropped and needs no retry.
- block_read_2xC holds its value until that port's next read completes. Writes do not alter it.
- Read-after-write to the same block returns the written data: the write commits before any later access is granted.

## Timing
- Reset (RESET=0, asynchronous, any state):
  - State goes to IDLE; cnt = 0; last-grant = I.
  - iBlkDone = dBlkDone = 0; block_read_2IC = block_read_2DC = 0; mem_busy = 0.
  - Array contents are not cleared.
  - A transaction in flight is abandoned. A write in flight is not committed unless its commit edge already occurred.
- Latency: a request sampled at edge t produces done high in the cycle after edge t+LATENCY. For reads, the data is valid in that same cycle.
- Back-to-back service: a pending request is accepted at edge t+LATENCY+2. Peak throughput is one block per LATENCY+2 cycles.
- mem_busy is high from edge t through the done cycle.

## Test plan
- **Single D-side read.** Preload array[3] = 256'hA5…A5; LATENCY = 4; dBlkRead = 1 with dAddr = 32'h60 sampled at edge t. Required: dBlkDone = 1 and block_read_2DC = A5…A5 only in the cycle after edge t+4; iBlkDone stays 0.
- **Write then read, I-side.** iBlkWrite with iAddr = 32'h20 and data = 256'h1234 (zero-extended); then iBlkRead of the same address. Required: read returns 256'h1234; block_read_2IC is unchanged by the write itself.
- **Conflict.** iBlkRead and dBlkRead both rise before edge t, just after reset. Required: D done after edge t+4; I accepted at edge t+6 and done after edge t+10. On a repeat conflict, I is served first.
- **Wrap-around.** DEPTH_BLKS = 1024; write to dAddr = 32'h8000 (index 0), then read dAddr = 32'h0. Required: the read returns the written block.
- **Reset mid-BUSY.** Pull RESET low 2 cycles into a write to block 5 (which holds old data X). Required: done never pulses; mem_busy = 0 immediately; a subsequent read of block 5 returns X.
- **LATENCY = 1 with read+write asserted together.** Required: done follows the accepting edge by exactly one cycle, and the operation is performed as a write.
